dm_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the single-port 128-bit data memory.

---
 rtl/dm_arbiter_pkg.sv | 20 ++
 rtl/dm_arb_pick.sv | 33 +++
 rtl/dm_arbiter.sv | 108 ++++++++++
 tb/tb_dm_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - memory command codes, sequencer state encodings and port ids
package dm_arbiter_pkg;

   // Memory command codes on dm_ctrl_sig
   localparam logic [1:0] MEMNOP = 2'b00;
   localparam logic [1:0] MEMWLD = 2'b01;
   localparam logic [1:0] MEMWST = 2'b10;

   localparam logic [1:0] DMA_IDLE = 2'd0;
   localparam logic [1:0] DMA_CMD  = 2'd1;
   localparam logic [1:0] DMA_WAIT = 2'd2;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   function automatic logic [1:0] mem_cmd(input logic we);
      return we ? MEMWST : MEMWLD;
   endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// rtl/dm_arb_pick.sv - two-port grant selection; round-robin under DM_ARB_RR_EN, else fixed priority
module dm_arb_pick
   import dm_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic [1:0] mask,
`ifdef DM_ARB_RR_EN
   input  logic       rr_ptr,
`endif
   output logic       grant,
   output logic       grant_id
);

   logic [1:0] elig;

   assign elig  = req & ~mask;
   assign grant = |elig;

   always_comb begin
      grant_id = PORT0;
`ifdef DM_ARB_RR_EN
      // On a tie the pointer names the winner
      if (elig == 2'b11)
         grant_id = rr_ptr;
      else if (elig[1])
         grant_id = PORT1;
`else
      if (!elig[0] && elig[1])
         grant_id = PORT1;
`endif
   end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port arbiter/sequencer for the single-port data memory (option: DM_ARB_RR_EN)
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        dm_ctrl_sig,
   output logic [ADDR_W-1:0] mem_ctrl_addr,
   output logic [DATA_W-1:0] dm_data_in,
   input  logic [DATA_W-1:0] dm_data_out
);

   logic [1:0]        state;
   logic              winner;
   logic              winner_we;
   logic              grant;
   logic              grant_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        mask;

`ifdef DM_ARB_RR_EN
   logic              rr_ptr;
`endif

   // Acks are only high in the IDLE cycle after WAIT, so they mask the port just served
   assign mask      = {ack1, ack0};
   assign sel_we    = grant_id ? we1    : we0;
   assign sel_addr  = grant_id ? addr1  : addr0;
   assign sel_wdata = grant_id ? wdata1 : wdata0;

   dm_arb_pick u_pick (
      .req      ({req1, req0}),
      .mask     (mask),
`ifdef DM_ARB_RR_EN
      .rr_ptr   (rr_ptr),
`endif
      .grant    (grant),
      .grant_id (grant_id)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= DMA_IDLE;
         winner        <= PORT0;
         winner_we     <= 1'b0;
         dm_ctrl_sig   <= MEMNOP;
         mem_ctrl_addr <= '0;
         dm_data_in    <= '0;
         ack0          <= 1'b0;
         ack1          <= 1'b0;
         rdata         <= '0;
`ifdef DM_ARB_RR_EN
         rr_ptr        <= PORT0;
`endif
      end else begin
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         dm_ctrl_sig <= MEMNOP;
         case (state)
            DMA_IDLE: begin
               if (grant) begin
                  winner        <= grant_id;
                  winner_we     <= sel_we;
                  dm_ctrl_sig   <= mem_cmd(sel_we);
                  mem_ctrl_addr <= sel_addr;
                  dm_data_in    <= sel_wdata;
                  state         <= DMA_CMD;
`ifdef DM_ARB_RR_EN
                  rr_ptr        <= ~grant_id;
`endif
               end
            end
            DMA_CMD: begin
               state <= DMA_WAIT;
            end
            DMA_WAIT: begin
               if (!winner_we)
                  rdata <= dm_data_out;
               if (winner == PORT1)
                  ack1 <= 1'b1;
               else
                  ack0 <= 1'b1;
               state <= DMA_IDLE;
            end
            default: begin
               state <= DMA_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed and table-driven bench for dm_arbiter with a registered memory model
module tb_dm_arbiter;

   localparam logic [1:0] C_NOP = 2'b00;
   localparam logic [1:0] C_LD  = 2'b01;
   localparam logic [1:0] C_ST  = 2'b10;

   logic         clk = 1'b0;
   logic         reset;
   logic         req0, req1, we0, we1;
   logic [31:0]  addr0, addr1;
   logic [127:0] wdata0, wdata1;
   logic         ack0, ack1;
   logic [127:0] rdata;
   logic [1:0]   dm_ctrl_sig;
   logic [31:0]  mem_ctrl_addr;
   logic [127:0] dm_data_in;
   logic [127:0] dm_data_out;

   int checks = 0;
   int errors = 0;
   int cmd_cnt = 0;
   int ack_cnt = 0;
   int both_cnt = 0;

   logic [127:0] mem [0:255];
   logic [127:0] sb  [0:255];
   logic [127:0] last_rdata;

   always #5 clk = ~clk;

   dm_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .req0          (req0),
      .req1          (req1),
      .we0           (we0),
      .we1           (we1),
      .addr0         (addr0),
      .addr1         (addr1),
      .wdata0        (wdata0),
      .wdata1        (wdata1),
      .ack0          (ack0),
      .ack1          (ack1),
      .rdata         (rdata),
      .dm_ctrl_sig   (dm_ctrl_sig),
      .mem_ctrl_addr (mem_ctrl_addr),
      .dm_data_in    (dm_data_in),
      .dm_data_out   (dm_data_out)
   );

   // Registered single-port memory; read data is zero on any non-load cycle
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= '0;
         dm_data_out <= '0;
      end else begin
         if (dm_ctrl_sig == C_ST) mem[mem_ctrl_addr[7:0]] <= dm_data_in;
         dm_data_out <= (dm_ctrl_sig == C_LD) ? mem[mem_ctrl_addr[7:0]] : '0;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (dm_ctrl_sig != C_NOP) cmd_cnt++;
         if (ack0 || ack1) ack_cnt++;
         if (ack0 && ack1) both_cnt++;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit p, input bit r, input bit we, input logic [31:0] a, input logic [127:0] d);
      if (p) begin
         req1 = r; we1 = we; addr1 = a; wdata1 = d;
      end else begin
         req0 = r; we0 = we; addr0 = a; wdata0 = d;
      end
   endtask

   // Single access from an idle arbiter; req is held through the ack cycle
   task automatic do_op(input bit p, input bit we, input logic [31:0] a, input logic [127:0] d,
                        input logic [127:0] exp_rdata);
      drive(p, 1'b1, we, a, d);
      tick;
      chk("cmd", {126'd0, dm_ctrl_sig}, {126'd0, we ? C_ST : C_LD});
      chk("addr", {96'd0, mem_ctrl_addr}, {96'd0, a});
      if (we) chk("data_in", dm_data_in, d);
      tick;
      chk("cmd_end", {126'd0, dm_ctrl_sig}, {126'd0, C_NOP});
      tick;
      chk("ack_hit", {126'd0, p ? ack1 : ack0}, 128'd1);
      chk("ack_other", {126'd0, p ? ack0 : ack1}, 128'd0);
      chk("rdata", rdata, exp_rdata);
      tick;
      chk("ack_pulse", {126'd0, ack0, ack1}, 128'd0);
      chk("no_dup", {126'd0, dm_ctrl_sig}, {126'd0, C_NOP});
      drive(p, 1'b0, we, a, d);
      if (we) sb[a[7:0]] = d;
      else last_rdata = exp_rdata;
   endtask

   // Both ports load at once (addr0=1, addr1=2); `first` is the expected winner
   task automatic tie(input bit first);
      logic [31:0] fa, sa;
      fa = first ? 32'd2 : 32'd1;
      sa = first ? 32'd1 : 32'd2;
      drive(1'b0, 1'b1, 1'b0, 32'd1, '0);
      drive(1'b1, 1'b1, 1'b0, 32'd2, '0);
      tick;
      chk("tie_addr1", {96'd0, mem_ctrl_addr}, {96'd0, fa});
      tick;
      tick;
      chk("tie_ack1", {126'd0, ack1, ack0}, first ? 128'd2 : 128'd1);
      chk("tie_rdata1", rdata, sb[fa[7:0]]);
      tick;
      drive(first, 1'b0, 1'b0, fa, '0);
      chk("tie_cmd2", {126'd0, dm_ctrl_sig}, {126'd0, C_LD});
      chk("tie_addr2", {96'd0, mem_ctrl_addr}, {96'd0, sa});
      tick;
      tick;
      chk("tie_ack2", {126'd0, ack1, ack0}, first ? 128'd1 : 128'd2);
      chk("tie_rdata2", rdata, sb[sa[7:0]]);
      tick;
      drive(~first, 1'b0, 1'b0, sa, '0);
      chk("tie_idle", {126'd0, dm_ctrl_sig}, {126'd0, C_NOP});
      last_rdata = sb[sa[7:0]];
   endtask

   typedef struct {
      bit           p;
      bit           we;
      logic [31:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{1'b0, 1'b1, 32'h05, {16{8'hA5}}, 128'd0};
      vecs[1] = '{1'b0, 1'b0, 32'h05, 128'd0, {16{8'hA5}}};
      vecs[2] = '{1'b1, 1'b1, 32'hFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, {16{8'hA5}}};
      vecs[3] = '{1'b1, 1'b0, 32'h05, 128'd0, {16{8'hA5}}};
      vecs[4] = '{1'b0, 1'b0, 32'hFF, 128'd0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
      vecs[5] = '{1'b1, 1'b0, 32'h07, 128'd0, 128'd0};
      vecs[6] = '{1'b0, 1'b1, 32'h00, {128{1'b1}}, 128'd0};
      vecs[7] = '{1'b1, 1'b0, 32'h00, 128'd0, {128{1'b1}}};

      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int i = 0; i < 256; i++) sb[i] = '0;
      last_rdata = '0;
      tick;
      tick;
      reset = 1'b0;
      tick;
      chk("rst_cmd", {126'd0, dm_ctrl_sig}, {126'd0, C_NOP});
      chk("rst_addr", {96'd0, mem_ctrl_addr}, 128'd0);
      chk("rst_din", dm_data_in, 128'd0);
      chk("rst_ack", {126'd0, ack0, ack1}, 128'd0);
      chk("rst_rdata", rdata, 128'd0);

      foreach (vecs[i])
         do_op(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

      // Reset in the middle of the command cycle aborts it at once
      drive(1'b0, 1'b1, 1'b1, 32'h03, {4{32'hDEAD_BEEF}});
      tick;
      chk("abort_pre", {126'd0, dm_ctrl_sig}, {126'd0, C_ST});
      #3 reset = 1'b1;
      #1;
      chk("abort_cmd", {126'd0, dm_ctrl_sig}, {126'd0, C_NOP});
      chk("abort_ack", {126'd0, ack0, ack1}, 128'd0);
      chk("abort_rdata", rdata, 128'd0);
      chk("abort_addr", {96'd0, mem_ctrl_addr}, 128'd0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      tick;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) sb[i] = '0;
      last_rdata = '0;
      tick;
      tick;
      chk("abort_no_ack", {126'd0, ack0, ack1}, 128'd0);

      do_op(1'b0, 1'b1, 32'd1, {8{16'h1111}}, 128'd0);
      do_op(1'b1, 1'b1, 32'd2, {8{16'h2222}}, 128'd0);
      tie(1'b0);

      // Port 0 served last, one idle cycle, then a tie: the policies disagree here
      do_op(1'b0, 1'b0, 32'd1, 128'd0, sb[1]);
      tick;
`ifdef DM_ARB_RR_EN
      tie(1'b1);
`else
      tie(1'b0);
`endif

      for (int i = 0; i < 200; i++) begin
         bit           p, we;
         logic [31:0]  a;
         logic [127:0] d;
         p  = 1'($urandom_range(0, 1));
         we = (i % 2) == 0;
         a  = 32'($urandom_range(0, 15));
         d  = {$urandom, $urandom, $urandom, $urandom};
         do_op(p, we, a, d, we ? last_rdata : sb[a[7:0]]);
      end

      chk("cmd_per_ack", 128'(cmd_cnt), 128'(ack_cnt));
      chk("both_acks", 128'(both_cnt), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
